// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions.
// Holds the active-low glyph table (seg[0]=a ... seg[6]=g) that the display
// decoder also uses, the blank anode pattern, the default stability
// threshold, and a helper that recognises a single active anode.
package seven_seg_pkg;

  // Consecutive identical samples needed before a digit is captured.
  localparam int unsigned STABLE_CYCLES_DEFAULT = 4;

  // All anodes off (active-low).
  localparam logic [3:0] AN_BLANK = 4'b1111;

  // Active-low glyphs, index = hex value shown.
  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

  // True when exactly one anode is driven low.
  function automatic logic one_anode_low(input logic [3:0] an);
    logic ok;
    case (an)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/seg_to_hex.sv
// Combinational glyph decoder.
// Ports:
//   seg     in  7  active-low segments, seg[0]=a ... seg[6]=g
//   nibble  out 4  decoded hex value (0 for unrecognised glyphs)
//   unknown out 1  high when seg matches none of the 16 hex glyphs
module seg_to_hex
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       unknown
);

  always_comb begin
    nibble  = 4'h0;
    unknown = 1'b0;
    case (seg)
      GLYPH_0: nibble = 4'h0;
      GLYPH_1: nibble = 4'h1;
      GLYPH_2: nibble = 4'h2;
      GLYPH_3: nibble = 4'h3;
      GLYPH_4: nibble = 4'h4;
      GLYPH_5: nibble = 4'h5;
      GLYPH_6: nibble = 4'h6;
      GLYPH_7: nibble = 4'h7;
      GLYPH_8: nibble = 4'h8;
      GLYPH_9: nibble = 4'h9;
      GLYPH_A: nibble = 4'hA;
      GLYPH_B: nibble = 4'hB;
      GLYPH_C: nibble = 4'hC;
      GLYPH_D: nibble = 4'hD;
      GLYPH_E: nibble = 4'hE;
      GLYPH_F: nibble = 4'hF;
      default: unknown = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_seg_reader.sv
// Reads back a scanned 4-digit seven-segment display and reassembles the
// 16-bit value being shown.
// Ports:
//   clock        in  1   system clock, rising edge
//   reset        in  1   synchronous active-high reset
//   an           in  4   scanned anodes, active-low, an[0] = rightmost digit
//   seg          in  7   segments, active-low, seg[0]=a ... seg[6]=g
//   value        out 16  last complete frame, digit k in value[4k+3:4k]
//   value_valid  out 1   one-cycle pulse when value updates
//   frame_err    out 1   qualified by value_valid: frame held an unknown glyph
//   seen         out 4   digits captured so far in the current frame
module seven_seg_reader
  import seven_seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] value,
  output logic        value_valid,
  output logic        frame_err,
  output logic [3:0]  seen
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] CNT_CAP = 8'(STABLE_CYCLES - 2);

  // Sample stage and the previous sample it is compared against.
  logic [3:0]  an_s, an_p;
  logic [6:0]  seg_s, seg_p;
  logic [7:0]  cnt, cnt_nxt;
  logic        same;

  logic [15:0] shadow, shadow_upd;
  logic        err_sticky, err_upd;
  logic [3:0]  sel, seen_upd;
  logic        capture, done;

  logic [3:0]  dec_nibble;
  logic        dec_unknown;

  seg_to_hex u_dec (
    .seg     (seg_s),
    .nibble  (dec_nibble),
    .unknown (dec_unknown)
  );

  assign same = (an_s == an_p) && (seg_s == seg_p);

  always_comb begin
    cnt_nxt = cnt;
    if (!same)
      cnt_nxt = '0;
    else if (cnt != CNT_MAX)
      cnt_nxt = cnt + 8'd1;
  end

  // Capture is taken on the edge at which the counter steps onto its
  // saturation value, so shadow/seen (and the completed frame) are written
  // in the same edge rather than one cycle after the counter settles.
  // Saturation guarantees this fires only once per dwell.
  assign capture = same && (cnt == CNT_CAP) && one_anode_low(an_s);

  assign sel      = ~an_s;
  assign seen_upd = seen | sel;
  assign done     = capture && (seen_upd == 4'b1111);
  assign err_upd  = err_sticky | dec_unknown;

  always_comb begin
    shadow_upd = shadow;
    for (int unsigned k = 0; k < 4; k++) begin
      if (sel[k])
        shadow_upd[4*k +: 4] = dec_nibble;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      an_s        <= AN_BLANK;
      seg_s       <= '1;
      an_p        <= AN_BLANK;
      seg_p       <= '1;
      cnt         <= '0;
      shadow      <= '0;
      err_sticky  <= 1'b0;
      seen        <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      an_s        <= an;
      seg_s       <= seg;
      an_p        <= an_s;
      seg_p       <= seg_s;
      cnt         <= cnt_nxt;
      value_valid <= 1'b0;
      if (capture) begin
        shadow <= shadow_upd;
        if (done) begin
          value       <= shadow_upd;
          value_valid <= 1'b1;
          frame_err   <= err_upd;
          seen        <= '0;
          err_sticky  <= 1'b0;
        end else begin
          seen       <= seen_upd;
          err_sticky <= err_upd;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_reader.sv
module tb_seven_seg_reader;

  localparam int unsigned S = 4;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] value;
  logic        value_valid;
  logic        frame_err;
  logic [3:0]  seen;

  always #5 clock = ~clock;

  seven_seg_reader #(.STABLE_CYCLES(S)) dut (
    .clock       (clock),
    .reset       (reset),
    .an          (an),
    .seg         (seg),
    .value       (value),
    .value_valid (value_valid),
    .frame_err   (frame_err),
    .seen        (seen)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic rst_seen;

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  typedef struct {
    logic [15:0] v;
    logic        e;
    int          due;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  // Drive a pattern right after an edge and hold it for n edges.
  task automatic show_raw(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic show(input logic [3:0] a, input int d, input int n);
    show_raw(a, GLYPH[d], n);
  endtask

  task automatic blank(input int n);
    show_raw(4'b1111, 7'b1111111, n);
  endtask

  // Called at the drive point of a frame's final digit.
  task automatic expect_frame(input logic [15:0] v, input logic e);
    exp_t x;
    x.v   = v;
    x.e   = e;
    x.due = cyc + int'(S) + 1;
    sb.push_back(x);
  endtask

  task automatic resync;
    @(posedge clock);
    #1;
  endtask

  // Per-cycle monitor: pulse timing from the scoreboard, value/frame_err
  // either the popped frame or the held previous one.
  exp_t        mon_x;
  logic [15:0] last_v;
  logic        last_e;
  logic        exp_v;

  always @(negedge clock) begin
    if (rst_seen) begin
      last_v = '0;
      last_e = 1'b0;
    end
    exp_v = (sb.size() > 0) && (sb[0].due == cyc);
    chk("value_valid", 32'(value_valid), 32'(exp_v));
    if (exp_v) begin
      mon_x  = sb.pop_front();
      last_v = mon_x.v;
      last_e = mon_x.e;
    end
    chk("value", 32'(value), 32'(last_v));
    chk("frame_err", 32'(frame_err), 32'(last_e));
  end

  initial begin
    reset = 1'b1;
    an    = 4'b1111;
    seg   = 7'b1111111;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_value", 32'(value), 32'h0);
    chk("reset_valid", 32'(value_valid), 32'h0);
    chk("reset_err", 32'(frame_err), 32'h0);
    chk("reset_seen", 32'(seen), 32'h0);
    resync();
    reset = 1'b0;

    // Basic scan 4,3,2,1.
    show(4'b1110, 4, 8);
    show(4'b1101, 3, 8);
    show(4'b1011, 2, 8);
    expect_frame(16'h1234, 1'b0);
    show(4'b0111, 1, 8);
    blank(4);
    @(negedge clock);
    chk("seen_after_frame", 32'(seen), 32'h0);
    resync();

    // Dwell one short of the threshold never captures.
    for (int r = 0; r < 2; r++) begin
      show(4'b1110, 7, int'(S) - 1);
      show(4'b1101, 6, int'(S) - 1);
      show(4'b1011, 5, int'(S) - 1);
      show(4'b0111, 4, int'(S) - 1);
    end
    blank(8);
    @(negedge clock);
    chk("short_dwell_seen", 32'(seen), 32'h0);
    resync();

    // Unknown glyph on digit 2, then a clean frame.
    show(4'b1110, 4, 8);
    show(4'b1101, 3, 8);
    show_raw(4'b1011, 7'b1111111, 8);
    expect_frame(16'h1034, 1'b1);
    show(4'b0111, 1, 8);
    show(4'b1110, 8, 8);
    show(4'b1101, 7, 8);
    show(4'b1011, 6, 8);
    expect_frame(16'h5678, 1'b0);
    show(4'b0111, 5, 8);

    // Blanking gaps and a multi-low anode pattern.
    show(4'b1110, 13, 8);
    blank(3);
    show(4'b1101, 12, 8);
    blank(3);
    show_raw(4'b1100, GLYPH[2], 10);
    @(negedge clock);
    chk("multi_low_seen", 32'(seen), 32'h3);
    resync();
    show(4'b1011, 11, 8);
    blank(3);
    expect_frame(16'hABCD, 1'b0);
    show(4'b0111, 10, 8);

    // Recapture of digit 0: latest glyph wins.
    show(4'b1110, 5, 8);
    @(negedge clock);
    chk("recapture_seen", 32'(seen), 32'h1);
    resync();
    show(4'b1110, 9, 8);
    show(4'b1101, 6, 8);
    show(4'b1011, 7, 8);
    expect_frame(16'h8769, 1'b0);
    show(4'b0111, 8, 8);

    // Reset mid-frame after two digits.
    show(4'b1110, 1, 8);
    show(4'b1101, 2, 8);
    @(negedge clock);
    chk("partial_seen", 32'(seen), 32'h3);
    resync();
    reset = 1'b1;
    blank(2);
    @(negedge clock);
    chk("midreset_value", 32'(value), 32'h0);
    chk("midreset_err", 32'(frame_err), 32'h0);
    chk("midreset_seen", 32'(seen), 32'h0);
    resync();
    reset = 1'b0;
    show(4'b1110, 15, 8);
    show(4'b1101, 0, 8);
    show(4'b1011, 14, 8);
    expect_frame(16'hCE0F, 1'b0);
    show(4'b0111, 12, 8);

    // Reset asserted on the very edge that would complete a frame.
    show(4'b1110, 3, 8);
    show(4'b1101, 3, 8);
    show(4'b1011, 3, 8);
    show(4'b0111, 3, int'(S));
    reset = 1'b1;
    blank(2);
    reset = 1'b0;
    @(negedge clock);
    chk("reset_wins_value", 32'(value), 32'h0);
    chk("reset_wins_seen", 32'(seen), 32'h0);
    resync();

    // Recovery frame.
    show(4'b0111, 9, 8);
    show(4'b1011, 10, 8);
    show(4'b1101, 11, 8);
    expect_frame(16'h9AB2, 1'b0);
    show(4'b1110, 2, 8);
    blank(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_reader.md
SEVEN_SEG_READER -- requirements
Module: seven_seg_reader

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, is the number of consecutive identical samples of an/seg required before a digit is captured; legal range 2..255.
REQ-002 clock  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 an  input  4  scanned anodes, active-low; an[0] is the rightmost digit.
REQ-005 seg  input  7  segments, active-low; seg[0]=a ... seg[6]=g.
REQ-006 value  output  16  last complete frame; an[k] digit maps to value[4k+3:4k].
REQ-007 value_valid  output  1  one-cycle pulse when value updates.
REQ-008 frame_err  output  1  valid with value_valid; 1 if any digit in the frame had an unknown glyph.
REQ-009 seen  output  4  digits captured so far in the current frame, for debug.

Function
REQ-010 Sampling: an and seg SHALL be registered once (sample stage) before any comparison; output timing is measured from the sample stage.
REQ-011 Stability counter: it SHALL clear to 0 when sampled {an,seg} differs from the previous sample, and otherwise increment, saturating at STABLE_CYCLES-1.
REQ-012 Capture: capture SHALL occur on the cycle the counter first reaches STABLE_CYCLES-1, and only once per dwell; a dwell is a run of identical samples.
REQ-013 Valid anode: an is valid only when exactly one bit is 0; 4'b1111 (blanking) and multi-low patterns SHALL NOT capture and SHALL NOT alter seen.
REQ-014 Glyph decode, seg[6:0] to nibble: 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9, 0001000=A, 0000011=b, 1000110=C, 0100001=d, 0000110=E, 0001110=F.
REQ-015 Unknown glyph: any other pattern SHALL capture nibble 0 and set the frame error flag.
REQ-016 Capture effect: the nibble SHALL be written into the shadow slot for the low anode, and the matching seen bit SHALL be set.
REQ-017 Recapture: a re-capture of an already-seen digit before the frame completes SHALL overwrite that slot (latest wins); the error flag stays sticky for the frame.
REQ-018 Frame completion: on the cycle the capture makes seen==4'b1111, the following cycle SHALL have value=shadow (including the new nibble), value_valid=1, frame_err=sticky flag OR the new digit's error, and seen=0 with the sticky flag cleared.
REQ-019 Latency: value_valid SHALL assert exactly STABLE_CYCLES+1 clocks after the final digit's first appearance at the an/seg pins.
REQ-020 Hold: value and frame_err SHALL hold between frames; value_valid SHALL be 0 at all other times.
REQ-021 Order: digit scan order SHALL be irrelevant; any order completes a frame.

Reset
REQ-022 While reset=1 at a clock edge, the following SHALL hold: value=16'h0000, value_valid=0, frame_err=0, seen=4'b0000, shadow=0, counter=0, sample registers=all ones (blank).
REQ-023 Reset mid-frame SHALL discard the partial frame; no value_valid SHALL be produced for it.
REQ-024 Reset SHALL take priority over a capture or completion occurring in the same cycle.

Structure
REQ-025 Shared package seven_seg_pkg SHALL hold the 16 glyph constants (the same table used by the display decoder), the blank anode constant 4'b1111, and the default STABLE_CYCLES value.
REQ-026 One combinational sub-module seg_to_hex SHALL perform the decode: input seg[6:0]; outputs nibble[3:0] and unknown.
REQ-027 Everything else SHALL be in seven_seg_reader: sample registers, counter, seen/shadow registers, and output registers.

Verification
REQ-028 Scan pattern: after reset, scan an=1110/1101/1011/0111 with glyphs 4,3,2,1, each held 8 cycles -> one value_valid with value=16'h1234 and frame_err=0.
REQ-029 Short dwell: hold each digit only STABLE_CYCLES-1 cycles -> no capture, seen stays 0, no value_valid.
REQ-030 Unknown glyph: digit 2 carries unknown glyph 7'b1111111 -> value=16'h1034 and frame_err=1; the next clean frame gives frame_err=0.
REQ-031 Blanking and multi-low anodes: insert an=1111 blanking for 3 cycles between digits, and an=1100 for 10 cycles -> neither captures; the frame still completes with the correct value.
REQ-032 Recapture: digit 0 is shown as 5, then 9, before the others -> value[3:0]=9.
REQ-033 Mid-frame reset: assert reset after 2 of 4 digits -> all outputs 0 and seen=0, no pulse; a full subsequent frame -> correct value.
